// File: rtl/if_stage.sv
// Instruction fetch stage: drives one-at-a-time requests to instruction memory
// and presents returned words (with their PC) to the operand-fetch stage.
//
// state | meaning
// ------+-------------------------------------------------------------------
// FETCH | request asserted at the current PC, waiting for memory to accept
// WAIT  | request accepted, waiting for read data (squash_q marks a stale one)
// HOLD  | word returned while OF was stalled; parked in the hold buffer
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_OF_INST,
    output logic [31:0] IF_OF_PC,
    output logic        IF_OF_VALID
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;

    logic        accept;
    logic        out_free;

    // Memory request is a pure function of state; gated so nothing leaks out during reset.
    always_comb begin
        imem_req  = (state_q == FETCH) && rst_n;
        imem_addr = pc_q;
    end

    // Next-state, PC, squash, hold buffer and output register computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;

        accept   = (state_q == FETCH) && imem_ready;
        out_free = !out_valid_q || !stall;

        if (isBranchTaken) begin
            // Redirect wins over everything, including a stalled OF.
            pc_d        = branchPC & PC_ALIGN_MASK;
            out_valid_d = 1'b0;
            // A request still in flight must have its data dropped when it lands;
            // a word landing on this very edge is simply not captured.
            if (accept || ((state_q == WAIT) && !imem_rvalid)) begin
                state_d  = WAIT;
                squash_d = 1'b1;
            end else begin
                state_d  = FETCH;
                squash_d = 1'b0;
            end
        end else begin
            // Default consumption: OF took the instruction and nothing replaces it.
            if (!stall) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                FETCH: begin
                    if (accept) begin
                        state_d = WAIT;
                    end
                end

                WAIT: begin
                    if (imem_rvalid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = FETCH;
                        end else begin
                            pc_d = pc_q + 32'd4;
                            if (out_free) begin
                                out_inst_d  = imem_rdata;
                                out_pc_d    = pc_q;
                                out_valid_d = 1'b1;
                                state_d     = FETCH;
                            end else begin
                                hold_inst_d = imem_rdata;
                                hold_pc_d   = pc_q;
                                state_d     = HOLD;
                            end
                        end
                    end
                end

                HOLD: begin
                    // Outputs are occupied and frozen until OF releases the stall.
                    if (!stall) begin
                        out_inst_d  = hold_inst_q;
                        out_pc_d    = hold_pc_q;
                        out_valid_d = 1'b1;
                        state_d     = FETCH;
                    end
                end

                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC_ALIGNED;
            squash_q    <= 1'b0;
            hold_inst_q <= 32'h0;
            hold_pc_q   <= 32'h0;
            out_inst_q  <= 32'h0;
            out_pc_q    <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output register drive.
    always_comb begin
        IF_OF_INST  = out_inst_q;
        IF_OF_PC    = out_pc_q;
        IF_OF_VALID = out_valid_q;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small latency-programmable memory model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        isBranchTaken;
    logic [31:0] branchPC;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req,   imem_req_w;
    logic [31:0] imem_addr,  imem_addr_w;
    logic [31:0] if_inst,    if_inst_w;
    logic [31:0] if_pc,      if_pc_w;
    logic        if_valid,   if_valid_w;

    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        sel_wrap = 1'b0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .isBranchTaken(isBranchTaken), .branchPC(branchPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_OF_INST(if_inst), .IF_OF_PC(if_pc), .IF_OF_VALID(if_valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .isBranchTaken(isBranchTaken), .branchPC(branchPC),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_OF_INST(if_inst_w), .IF_OF_PC(if_pc_w), .IF_OF_VALID(if_valid_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, memory answers mem_lat cycles after acceptance.
    task automatic cyc(input logic st, input logic br, input logic [31:0] bpc);
        logic        acc;
        logic [31:0] aa;
        @(negedge clk);
        stall         = st;
        isBranchTaken = br;
        branchPC      = bpc;
        imem_rvalid   = (cnt == 1);
        imem_rdata    = pend_addr ^ 32'hA5A5_0000;
        #1;
        acc = sel_wrap ? (imem_req_w && imem_ready) : (imem_req && imem_ready);
        aa  = sel_wrap ? imem_addr_w : imem_addr;
        @(posedge clk);
        #1;
        if (cnt > 0) cnt--;
        if (acc) begin
            cnt       = mem_lat;
            pend_addr = aa;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        cnt        = 0;
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        isBranchTaken = 1'b0;
        branchPC      = 32'h0;
        imem_ready    = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;

        // Reset state
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);

        // Basic fetch, 1-cycle memory
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("b_valid0", {31'h0, if_valid}, 32'h1);
        chk("b_pc0", if_pc, 32'h0);
        chk("b_inst0", if_inst, 32'hA5A5_0000);
        cyc(1'b0, 1'b0, 32'h0);
        chk("b_drop", {31'h0, if_valid}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("b_valid4", {31'h0, if_valid}, 32'h1);
        chk("b_pc4", if_pc, 32'h4);
        chk("b_inst4", if_inst, 32'hA5A5_0004);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("b_pc8", if_pc, 32'h8);
        chk("b_inst8", if_inst, 32'hA5A5_0008);

        // Backpressure into HOLD
        do_reset();
        repeat (4) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("bp_valid", {31'h0, if_valid}, 32'h1);
        chk("bp_pc", if_pc, 32'h4);
        cyc(1'b1, 1'b0, 32'h0);
        chk("hold_pc", if_pc, 32'h4);
        chk("hold_inst", if_inst, 32'hA5A5_0004);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("hold2_pc", if_pc, 32'h4);
        chk("hold2_req", {31'h0, imem_req}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("rel_pc", if_pc, 32'h8);
        chk("rel_inst", if_inst, 32'hA5A5_0008);
        chk("rel_valid", {31'h0, if_valid}, 32'h1);
        chk("rel_req", {31'h0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'hC);

        // Redirect with squash, 2-cycle memory
        do_reset();
        mem_lat = 2;
        repeat (6) cyc(1'b0, 1'b0, 32'h0);
        chk("sq_pre_pc", if_pc, 32'h4);
        chk("sq_pre_valid", {31'h0, if_valid}, 32'h1);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h100);
        chk("sq_valid", {31'h0, if_valid}, 32'h0);
        chk("sq_req", {31'h0, imem_req}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("sq_drop_valid", {31'h0, if_valid}, 32'h0);
        chk("sq_req2", {31'h0, imem_req}, 32'h1);
        chk("sq_addr", imem_addr, 32'h100);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("sq_wait_valid", {31'h0, if_valid}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("sq_new_pc", if_pc, 32'h100);
        chk("sq_new_inst", if_inst, 32'hA5A5_0100);
        chk("sq_new_valid", {31'h0, if_valid}, 32'h1);

        // Redirect overrides stall, misaligned target
        imem_ready = 1'b0;
        cyc(1'b1, 1'b1, 32'h203);
        chk("bs_valid", {31'h0, if_valid}, 32'h0);
        chk("bs_req", {31'h0, imem_req}, 32'h1);
        chk("bs_addr", imem_addr, 32'h200);

        // Redirect coinciding with returning data
        imem_ready = 1'b1;
        mem_lat    = 1;
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h300);
        chk("co_valid", {31'h0, if_valid}, 32'h0);
        chk("co_req", {31'h0, imem_req}, 32'h1);
        chk("co_addr", imem_addr, 32'h300);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("co_pc", if_pc, 32'h300);
        chk("co_inst", if_inst, 32'hA5A5_0300);

        // Wrap-around from top of address space
        sel_wrap = 1'b1;
        do_reset();
        chk("wr_addr0", imem_addr_w, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wr_pc", if_pc_w, 32'hFFFF_FFFC);
        chk("wr_inst", if_inst_w, 32'h5A5A_FFFC);
        chk("wr_valid", {31'h0, if_valid_w}, 32'h1);
        chk("wr_next", imem_addr_w, 32'h0);
        sel_wrap = 1'b0;

        // Reset while a request is outstanding; stale data arrives afterwards
        do_reset();
        mem_lat = 1;
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        mem_lat = 2;
        cyc(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 32'h0);
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        cyc(1'b0, 1'b0, 32'h0);
        chk("mr_valid", {31'h0, if_valid}, 32'h0);
        chk("mr_inst", if_inst, 32'h0);
        chk("mr_pc", if_pc, 32'h0);
        chk("mr_req", {31'h0, imem_req}, 32'h1);
        chk("mr_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        mem_lat    = 1;
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("mr_new_pc", if_pc, 32'h0);
        chk("mr_new_inst", if_inst, 32'hA5A5_0000);
        chk("mr_new_valid", {31'h0, if_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide these ports: clk  in  1  rising-edge clock.
REQ-002 SHALL provide these ports: rst_n  in  1  reset; synchronous, active-low.
REQ-003 SHALL provide these ports: stall  in  1  OF cannot accept a new instruction this cycle.
REQ-004 SHALL provide these ports: isBranchTaken  in  1  redirect request from EX.
REQ-005 SHALL provide these ports: branchPC  in  32  redirect target.
REQ-006 SHALL provide these ports: imem_req  out  1  fetch request.
REQ-007 SHALL provide these ports: imem_addr  out  32  fetch address.
REQ-008 SHALL provide these ports: imem_ready  in  1  memory accepts request.
REQ-009 SHALL provide these ports: imem_rvalid  in  1  read data valid.
REQ-010 SHALL provide these ports: imem_rdata  in  32  instruction word.
REQ-011 SHALL provide these ports: IF_OF_INST  out  32  instruction to OF.
REQ-012 SHALL provide these ports: IF_OF_PC  out  32  PC of IF_OF_INST.
REQ-013 SHALL provide these ports: IF_OF_VALID  out  1  IF_OF_INST/IF_OF_PC hold a live instruction.
REQ-014 SHALL provide these parameters: RESET_PC, 32'h0000_0000, first fetch address.

Function
REQ-015 SHALL keep a 32-bit fetch PC; every increment is +4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-016 SHALL force bits [1:0] of every loaded PC (RESET_PC, branchPC) to 0.
REQ-017 SHALL use FSM states FETCH, WAIT, HOLD.
REQ-018 SHALL have at most one outstanding memory request at any time.
REQ-019 In FETCH: imem_req=1, imem_addr=PC; on imem_req&imem_ready, go to WAIT; otherwise stay.
REQ-020 In WAIT: imem_req=0; imem_rvalid is legal no earlier than 1 cycle after acceptance.
REQ-021 On rvalid in WAIT (not squashed), PC SHALL become PC+4 in the same edge.
REQ-022 On rvalid in WAIT, if output register is free (IF_OF_VALID=0 or stall=0), the word SHALL load into IF_OF_INST/PC with IF_OF_VALID=1, then go to FETCH.
REQ-023 On rvalid in WAIT, if output register is occupied and stall=1, the word SHALL go into a one-entry hold buffer, then go to HOLD.
REQ-024 In HOLD: imem_req=0; output registers frozen.
REQ-025 In HOLD, on the first cycle with stall=0: hold buffer moves to output (VALID=1), then go to FETCH.
REQ-026 When stall=0 and no new word is loaded, IF_OF_VALID SHALL drop to 0 next cycle (instruction consumed).
REQ-027 When stall=1, IF_OF_INST/PC/VALID SHALL hold their values.
REQ-028 isBranchTaken SHALL override stall and all other events; on that edge:
  - PC <= {branchPC[31:2],2'b00}
  - IF_OF_VALID <= 0
  - hold buffer discarded
  - next state FETCH
REQ-029 If isBranchTaken occurs with a request outstanding (in WAIT, or accepted this cycle), SHALL set a squash flag, enter WAIT, and discard the next rvalid without touching PC or outputs; then go to FETCH at branchPC.
REQ-030 If isBranchTaken and rvalid coincide, the returning word SHALL be discarded; no squash flag is set.
REQ-031 rvalid outside WAIT SHALL be ignored.
REQ-032 Sustained throughput SHALL be one instruction per 2 cycles for a 1-cycle-latency memory.

Reset
REQ-033 On rising clk with rst_n=0, reset SHALL apply regardless of other inputs: PC=RESET_PC, state=FETCH, squash=0, hold buffer empty, IF_OF_VALID=0, IF_OF_INST=0, IF_OF_PC=0.
REQ-034 imem_req SHALL be 0 while rst_n=0.
REQ-035 imem_req SHALL assert in the first cycle after rst_n rises.
REQ-036 Reset mid-request SHALL abandon the request; any later rvalid SHALL be ignored until a new request is accepted.

Verification
REQ-037 Basic fetch: 1-cycle-latency memory returning addr^32'hA5A5_0000, stall=0 -> IF_OF_PC sequence 0,4,8; each IF_OF_INST matches; VALID pulses every 2nd cycle.
REQ-038 Backpressure: stall=1 while output holds PC 4 and the PC 8 word returns -> state HOLD, outputs frozen at PC 4; stall=0 -> PC 8 presented next cycle; next fetch addr 12.
REQ-039 Redirect with squash: isBranchTaken, branchPC=32'h100, while in WAIT for addr 8 -> addr-8 data discarded; next imem_addr=32'h100; VALID=0 until 0x100 word returns.
REQ-040 Redirect vs stall: isBranchTaken=1, stall=1, branchPC=32'h203 -> VALID=0 next cycle; next fetch addr 32'h200.
REQ-041 Wrap-around: RESET_PC=32'hFFFF_FFFC -> first IF_OF_PC=32'hFFFF_FFFC, next fetch addr 0.
REQ-042 Reset mid-request: rst_n=0 during WAIT, late rvalid arrives -> outputs stay 0; first fetch after reset at RESET_PC.
